parity_frame_receiver: RTL and testbench
========================================

PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4: data bits per frame.
REQ-002 The block SHALL have parameter ODD, default 0: 0 = even parity expected, 1 = odd parity expected.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-004 Port: clk, input, 1 -- single clock; all logic on rising edge.
REQ-005 Port: rst, input, 1 -- reset; synchronous and active-high.
REQ-006 Port: sample_en, input, 1 -- bit-rate strobe; `sin` is sampled only on clk edges where sample_en=1.
REQ-007 Port: sin, input, 1 -- serial line; idle high.
REQ-008 Port: data_out, output, DATA_W -- last received data word.
REQ-009 Port: data_valid, output, 1 -- one-cycle pulse per completed frame.
REQ-010 Port: parity_err, output, 1 -- parity mismatch on last frame.
REQ-011 Port: frame_err, output, 1 -- stop bit of last frame was 0.
REQ-012 Port: err_count, output, CNT_W -- saturating count of errored frames.
REQ-013 Port: busy, output, 1 -- high while a frame is in progress (state != IDLE).

Function
REQ-014 The frame SHALL be: start bit (0), then DATA_W data bits LSB first, then one parity bit, then one stop bit (1); one bit per sample_en edge.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE -> DATA SHALL occur on a sample_en edge with sin=0; with sin=1 the FSM stays in IDLE.
REQ-017 DATA SHALL shift in exactly DATA_W bits using a bit counter 0..DATA_W-1, then go to PARITY.
REQ-018 PARITY SHALL capture the parity bit on one sample_en edge, then go to STOP.
REQ-019 STOP SHALL capture the stop bit on one sample_en edge, then return to IDLE.
REQ-020 A new start bit SHALL be accepted on the first sample_en edge after the STOP sample.
REQ-021 Cycles with sample_en=0 SHALL leave the state, bit counter and shift register unchanged.
REQ-022 On the clk edge sampling the stop bit, the block SHALL register data_out, parity_err and frame_err, and SHALL set data_valid=1 for exactly the following cycle.
REQ-023 parity_err SHALL be (XOR of data bits XOR parity bit) != ODD.
REQ-024 frame_err SHALL be 1 iff the sampled stop bit is 0.
REQ-025 data_out, parity_err and frame_err SHALL hold their values until the next completed frame.
REQ-026 A frame with both errors SHALL assert both flags and SHALL increment err_count by exactly 1.
REQ-027 err_count SHALL increment by 1 on the same edge as REQ-022 when parity_err or frame_err is set, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-028 The data of an errored frame SHALL still be presented on data_out with data_valid.
REQ-029 There SHALL be no mid-frame abort: a 0 on sin during STOP is a framing error, not a new start bit.

Reset
REQ-030 When rst=1 at a clk edge, the block SHALL force state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, err_count=0 and busy=0.
REQ-031 rst SHALL take priority over sample_en.
REQ-032 Reset mid-frame SHALL discard the partial frame with no data_valid pulse.

Verification
REQ-033 Even parity, DATA_W=4, sin sequence 0,0,1,0,1,0,1 (start, 1010 LSB first, parity 0, stop 1) -> one data_valid pulse, data_out=1010, parity_err=0, frame_err=0, err_count=0.
REQ-034 Frame 1111 with parity bit 1 and stop 1 -> data_out=1111, parity_err=1, frame_err=0, err_count=1.
REQ-035 Frame 0110 with parity 0 and stop 0 -> frame_err=1, parity_err=0, err_count increments by 1; a back-to-back frame 0011 with parity 0 and stop 1 -> clean frame, flags cleared.
REQ-036 ODD=1, frame 0000 with parity 1 -> parity_err=0; same frame with parity 0 -> parity_err=1.
REQ-037 rst asserted after 2 data bits -> busy=0 next cycle and no data_valid; a following full frame decodes correctly.
REQ-038 CNT_W=2 with 5 consecutive parity-errored frames -> err_count sequence 1,2,3,3,3; sample_en gaps of 3 cycles between bits -> same results as continuous strobing.

Source files
------------

// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver: receives start/data/parity/stop serial frames and flags parity and framing errors
module parity_frame_receiver #(
  parameter int DATA_W = 4,
  parameter int ODD = 0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);
  localparam int BC_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [BC_W-1:0] bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [DATA_W:0] shift_in;
  logic par, par_n, done, last, perr, ferr;
  assign shift_in = {sin, shift};
  assign last = bit_cnt == BC_W'(DATA_W - 1);
  assign perr = ^{shift, par, ODD != 0};
  assign ferr = ~sin;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shift_n = shift;
    par_n = par;
    done = 1'b0;
    if (sample_en)
      case (state)
        IDLE: begin
          state_n = sin ? IDLE : DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          shift_n = shift_in[DATA_W:1];
          bit_cnt_n = last ? '0 : bit_cnt + 1'b1;
          state_n = last ? PARITY : DATA;
        end
        PARITY: begin
          par_n = sin;
          state_n = STOP;
        end
        default: begin
          done = 1'b1;
          state_n = IDLE;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shift <= shift_n;
      par <= par_n;
      data_valid <= done;
      if (done) begin
        data_out <= shift;
        parity_err <= perr;
        frame_err <= ferr;
        if ((perr || ferr) && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb_parity_frame_receiver: directed frames against default, odd-parity and 2-bit-counter instances
module tb_parity_frame_receiver;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, sin = 1'b1;
  logic [3:0] d_out, o_out, c_out;
  logic d_val, d_perr, d_ferr, d_busy;
  logic o_val, o_perr, o_ferr, o_busy;
  logic c_val, c_perr, c_ferr, c_busy;
  logic [7:0] d_cnt, o_cnt;
  logic [1:0] c_cnt;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  parity_frame_receiver dut_d (.clk(clk), .rst(rst), .sample_en(sample_en), .sin(sin), .data_out(d_out),
    .data_valid(d_val), .parity_err(d_perr), .frame_err(d_ferr), .err_count(d_cnt), .busy(d_busy));
  parity_frame_receiver #(.ODD(1)) dut_o (.clk(clk), .rst(rst), .sample_en(sample_en), .sin(sin), .data_out(o_out),
    .data_valid(o_val), .parity_err(o_perr), .frame_err(o_ferr), .err_count(o_cnt), .busy(o_busy));
  parity_frame_receiver #(.CNT_W(2)) dut_c (.clk(clk), .rst(rst), .sample_en(sample_en), .sin(sin), .data_out(c_out),
    .data_valid(c_val), .parity_err(c_perr), .frame_err(c_ferr), .err_count(c_cnt), .busy(c_busy));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bit_tx(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      sample_en = 1'b0;
      sin = b;
      tick();
    end
    sample_en = 1'b1;
    sin = b;
    tick();
    sample_en = 1'b0;
    sin = 1'b1;
  endtask
  task automatic frame(input logic [3:0] d, input logic p, input logic s, input int gap);
    bit_tx(1'b0, gap);
    for (int i = 0; i < 4; i++) bit_tx(d[i], gap);
    bit_tx(p, gap);
    bit_tx(s, gap);
  endtask
  task automatic chk_d(input string tag, input logic [3:0] d, input logic pe, input logic fe, input logic [7:0] c);
    chk({tag, ".valid"}, 32'(d_val), 32'd1);
    chk({tag, ".data"}, 32'(d_out), 32'(d));
    chk({tag, ".perr"}, 32'(d_perr), 32'(pe));
    chk({tag, ".ferr"}, 32'(d_ferr), 32'(fe));
    chk({tag, ".cnt"}, 32'(d_cnt), 32'(c));
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst.data", 32'(d_out), 32'd0);
    chk("rst.valid", 32'(d_val), 32'd0);
    chk("rst.perr", 32'(d_perr), 32'd0);
    chk("rst.ferr", 32'(d_ferr), 32'd0);
    chk("rst.cnt", 32'(d_cnt), 32'd0);
    chk("rst.busy", 32'(d_busy), 32'd0);
    bit_tx(1'b1, 0);
    chk("idle.busy", 32'(d_busy), 32'd0);
    bit_tx(1'b0, 0);
    chk("start.busy", 32'(d_busy), 32'd1);
    for (int i = 0; i < 4; i++) bit_tx(i[0], 0);
    bit_tx(1'b0, 0);
    bit_tx(1'b1, 0);
    chk_d("f1010", 4'b1010, 1'b0, 1'b0, 8'd0);
    tick();
    chk("f1010.pulse", 32'(d_val), 32'd0);
    chk("f1010.hold", 32'(d_out), 32'hA);
    frame(4'b1111, 1'b1, 1'b1, 0);
    chk_d("f1111", 4'b1111, 1'b1, 1'b0, 8'd1);
    frame(4'b0110, 1'b0, 1'b0, 0);
    chk_d("f0110", 4'b0110, 1'b0, 1'b1, 8'd2);
    chk("f0110.busy", 32'(d_busy), 32'd0);
    frame(4'b0011, 1'b0, 1'b1, 0);
    chk_d("f0011", 4'b0011, 1'b0, 1'b0, 8'd2);
    frame(4'b0000, 1'b1, 1'b1, 0);
    chk("odd.p1.valid", 32'(o_val), 32'd1);
    chk("odd.p1.perr", 32'(o_perr), 32'd0);
    chk("even.p1.perr", 32'(d_perr), 32'd1);
    frame(4'b0000, 1'b0, 1'b1, 0);
    chk("odd.p0.perr", 32'(o_perr), 32'd1);
    chk("even.p0.perr", 32'(d_perr), 32'd0);
    chk("even.p0.cnt", 32'(d_cnt), 32'd3);
    bit_tx(1'b0, 0);
    bit_tx(1'b1, 0);
    bit_tx(1'b0, 0);
    chk("mid.busy", 32'(d_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.busy", 32'(d_busy), 32'd0);
    chk("midrst.valid", 32'(d_val), 32'd0);
    chk("midrst.cnt", 32'(d_cnt), 32'd0);
    for (int i = 0; i < 6; i++) bit_tx(1'b1, 0);
    chk("midrst.novalid", 32'(d_val), 32'd0);
    chk("midrst.data", 32'(d_out), 32'd0);
    frame(4'b0101, 1'b0, 1'b1, 0);
    chk_d("f0101", 4'b0101, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      frame(4'b1000, 1'b0, 1'b1, 3);
      chk("sat.valid", 32'(c_val), 32'd1);
      chk("sat.data", 32'(c_out), 32'h8);
      chk("sat.perr", 32'(c_perr), 32'd1);
      chk("sat.cnt", 32'(c_cnt), k < 3 ? k + 1 : 3);
    end
    chk("gap.cnt8", 32'(d_cnt), 32'd5);
    frame(4'b1010, 1'b0, 1'b1, 3);
    chk("gap.clean.valid", 32'(c_val), 32'd1);
    chk("gap.clean.data", 32'(c_out), 32'hA);
    chk("gap.clean.perr", 32'(c_perr), 32'd0);
    chk("gap.clean.cnt", 32'(c_cnt), 32'd3);
    tick();
    chk("gap.clean.pulse", 32'(c_val), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
